asy_fifo_wr_arb: RTL and testbench

Write-side round-robin arbiter that shares the single write port of the team's asynchronous FIFO among N_REQ requesters in the wr_clk domain. Each requester presents a valid/ready/last stream; the arbiter grants one requester at a time for a burst of up to MAX_BURST beats and drives the FIFO's wr_en/wr_data, honouring fifo_full. It sits directly in front of the FIFO's write port; the read side is untouched.

---
 rtl/asy_fifo_pkg.sv | 14 +
 rtl/asy_fifo_wr_arb_if.sv | 15 +
 rtl/asy_fifo_wr_arb_rr_pick.sv | 31 +++
 rtl/asy_fifo_wr_arb.sv | 120 ++++++++++++
 tb/tb_asy_fifo_wr_arb.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asy_fifo_pkg.sv
// Shared types for the async FIFO write-side arbiter: FSM state encoding and ID width helper.
package asy_fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Requester index width; never zero so a 1-requester build still has a legal vector.
  function automatic int id_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/asy_fifo_wr_arb_if.sv
// Requester-side bundle of the write arbiter: N_REQ parallel valid/ready/last streams.
interface asy_fifo_wr_arb_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  // Beat i transfers in a cycle where req_valid[i] & req_ready[i]; req_data/req_last
  // describe that beat. Valid may drop without a transfer; ready never depends on valid.
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/asy_fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i scanning upward from rr_ptr_i.
module rr_pick
  import asy_fifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  rr_ptr_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  int              sum;
  logic [ID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    sum   = 0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = int'(rr_ptr_i) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = ID_W'(sum);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/asy_fifo_wr_arb.sv
// Round-robin write-port arbiter in front of the async FIFO, bursts of up to MAX_BURST beats.
// Define ASY_FIFO_ARB_TAG_EN to prepend the granted requester id to each written word.
module asy_fifo_wr_arb
  import asy_fifo_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8,
  localparam int ID_W     = id_w(N_REQ),
  localparam int CNT_W    = $clog2(MAX_BURST + 1),
`ifdef ASY_FIFO_ARB_TAG_EN
  localparam int OUT_W    = WIDTH + ID_W
`else
  localparam int OUT_W    = WIDTH
`endif
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst_n,
  asy_fifo_wr_arb_if.slave     req,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [OUT_W-1:0]     fifo_wr_data,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output arb_state_e           dbg_state_o,
  output logic [ID_W-1:0]      dbg_rr_ptr_o,
  output logic [CNT_W-1:0]     dbg_beat_cnt_o
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             g_valid, g_last, beat;
  logic [WIDTH-1:0] g_data;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_i    (req.req_valid),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        g_valid = req.req_valid[i];
        g_last  = req.req_last[i];
        g_data  = req.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready depends only on registered grant and fifo_full, never on req_valid.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    req.req_ready = '0;
    beat          = 1'b0;
    fifo_wr_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        for (int i = 0; i < N_REQ; i++) begin
          req.req_ready[i] = (grant_q == ID_W'(i)) & ~fifo_full;
        end
        beat = g_valid & ~fifo_full;
        if (beat) begin
`ifdef ASY_FIFO_ARB_TAG_EN
          fifo_wr_data = {grant_q, g_data};
`else
          fifo_wr_data = g_data;
`endif
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (g_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign fifo_wr_en     = beat;
  assign grant_id       = grant_q;
  assign busy           = (state_q == ST_GRANT);
  assign dbg_state_o    = state_q;
  assign dbg_rr_ptr_o   = rr_ptr_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_asy_fifo_wr_arb.sv
// Bench for asy_fifo_wr_arb: per-requester beat queues, transaction-level arbitration model.
module tb_asy_fifo_wr_arb;
  import asy_fifo_pkg::*;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int MB    = 8;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;
  localparam int CAP   = 64;
`ifdef ASY_FIFO_ARB_TAG_EN
  localparam int OUT_W = W + ID_W;
`else
  localparam int OUT_W = W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic full;
  always #5 clk = ~clk;

  logic              fifo_wr_en;
  logic [OUT_W-1:0]  fifo_wr_data;
  logic [ID_W-1:0]   grant_id;
  logic              busy;
  arb_state_e        dbg_state;
  logic [ID_W-1:0]   dbg_rr_ptr;
  logic [CNT_W-1:0]  dbg_beat_cnt;

  asy_fifo_wr_arb_if #(.N_REQ(N), .WIDTH(W)) rif ();

  asy_fifo_wr_arb #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .wr_clk         (clk),
    .wr_rst_n       (rst_n),
    .req            (rif),
    .fifo_full      (full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .grant_id       (grant_id),
    .busy           (busy),
    .dbg_state_o    (dbg_state),
    .dbg_rr_ptr_o   (dbg_rr_ptr),
    .dbg_beat_cnt_o (dbg_beat_cnt)
  );

  // ---------------- bench state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who holds the grant, beats in this grant, next scan start.
  int m_busy, m_g, m_cnt, m_ptr;

  logic [W-1:0] s_data [N][CAP];
  logic         s_last [N][CAP];
  int           s_head [N];
  int           s_tail [N];
  int           vprob, full_mode, fprob;

  logic [OUT_W-1:0] exp_q[$];
  int               step_no, dut_beats, first_busy_step;
  logic             prev_busy;
  int               dut_grants[$];
  int               wr_src[$];
  int               wr_step[$];
  logic [OUT_W-1:0] last_wr_data;

  // ---------------- driver tasks ----------------
  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      s_head[i] = 0;
      s_tail[i] = 0;
    end
  endtask

  task automatic push_beat(input int i, input logic [W-1:0] d, input logic l);
    if (s_tail[i] < CAP) begin
      s_data[i][s_tail[i]] = d;
      s_last[i][s_tail[i]] = l;
      s_tail[i]++;
    end
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (s_head[i] < s_tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    logic [N-1:0]   v, l;
    logic [N*W-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (s_head[i] < s_tail[i]) begin
        d[i*W +: W] = s_data[i][s_head[i]];
        l[i]        = s_last[i][s_head[i]];
        v[i]        = ($urandom_range(99) < vprob);
      end
    end
    rif.req_valid = v;
    rif.req_data  = d;
    rif.req_last  = l;
    if (full_mode == 2)      full = 1'b1;
    else if (full_mode == 1) full = ($urandom_range(99) < fprob);
    else                     full = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
    clear_sources();
    exp_q.delete();
    prev_busy = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    drive();
    #2;
    rst_n = 1'b1;
  endtask

  // One clock: check outputs at negedge against the model, advance model at posedge.
  task automatic step();
    logic [N-1:0]     exp_ready;
    logic             exp_beat, exp_busy, rel;
    logic [OUT_W-1:0] word, got;
    int               g, idx;
    @(negedge clk);
    step_no++;
    exp_ready = '0;
    exp_beat  = 1'b0;
    exp_busy  = (m_busy != 0);
    g         = m_g;
    if (m_busy != 0) begin
      exp_ready[g] = ~full;
      exp_beat     = rif.req_valid[g] & ~full;
    end
    if (exp_beat) begin
`ifdef ASY_FIFO_ARB_TAG_EN
      word = {ID_W'(g), s_data[g][s_head[g]]};
`else
      word = s_data[g][s_head[g]];
`endif
      exp_q.push_back(word);
    end
    n_tests++;
    if (rif.req_ready !== exp_ready) begin
      n_fail++; $display("FAIL ready step %0d: got %b exp %b", step_no, rif.req_ready, exp_ready);
    end
    n_tests++;
    if (busy !== exp_busy) begin
      n_fail++; $display("FAIL busy step %0d: got %b exp %b", step_no, busy, exp_busy);
    end
    n_tests++;
    if (grant_id !== ID_W'(m_g)) begin
      n_fail++; $display("FAIL grant_id step %0d: got %0d exp %0d", step_no, grant_id, m_g);
    end
    n_tests++;
    if (dbg_rr_ptr !== ID_W'(m_ptr)) begin
      n_fail++; $display("FAIL rr_ptr step %0d: got %0d exp %0d", step_no, dbg_rr_ptr, m_ptr);
    end
    if (m_busy != 0) begin
      n_tests++;
      if (dbg_beat_cnt !== CNT_W'(m_cnt)) begin
        n_fail++; $display("FAIL beat_cnt step %0d: got %0d exp %0d", step_no, dbg_beat_cnt, m_cnt);
      end
    end
    n_tests++;
    if (fifo_wr_en !== exp_beat) begin
      n_fail++; $display("FAIL wr_en step %0d: got %b exp %b", step_no, fifo_wr_en, exp_beat);
    end
    if (fifo_wr_en === 1'b1) begin
      dut_beats++;
      wr_src.push_back(int'(grant_id));
      wr_step.push_back(step_no);
      last_wr_data = fifo_wr_data;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL wr_data step %0d: got unexpected write %h exp none", step_no, fifo_wr_data);
      end else begin
        got = exp_q.pop_front();
        if (fifo_wr_data !== got) begin
          n_fail++; $display("FAIL wr_data step %0d: got %h exp %h", step_no, fifo_wr_data, got);
        end
      end
    end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL missed_write step %0d: got no write exp %h", step_no, exp_q[0]);
      exp_q.delete();
    end
    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      dut_grants.push_back(int'(grant_id));
      if (first_busy_step == 0) first_busy_step = step_no;
    end
    prev_busy = busy;

    @(posedge clk);
    if (m_busy != 0) begin
      if (exp_beat) begin
        rel = s_last[g][s_head[g]] || (m_cnt + 1 == MB);
        m_cnt++;
        s_head[g]++;
        if (rel) begin
          m_busy = 0;
          m_ptr  = (g + 1) % N;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (rif.req_valid[idx]) begin
          m_g = idx; m_busy = 1; m_cnt = 0;
          break;
        end
      end
    end
    #1;
    drive();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((any_pending() || m_busy != 0) && n < bound) begin
      step();
      n++;
    end
    n_tests++;
    if (any_pending() || m_busy != 0) begin
      n_fail++; $display("FAIL drain_timeout: got still busy after %0d cycles exp drained", bound);
    end
  endtask

  task automatic clear_logs();
    step_no = 0; dut_beats = 0; first_busy_step = 0;
    dut_grants.delete(); wr_src.delete(); wr_step.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    full = 1'b0;
    rif.req_valid = '1;
    rif.req_data  = '1;
    rif.req_last  = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (rif.req_ready !== '0) begin n_fail++; $display("FAIL rst_ready: got %b exp 0", rif.req_ready); end
    n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b exp 0", fifo_wr_en); end
    n_tests++; if (fifo_wr_data !== '0) begin n_fail++; $display("FAIL rst_wr_data: got %h exp 0", fifo_wr_data); end
    n_tests++; if (grant_id !== '0) begin n_fail++; $display("FAIL rst_grant: got %0d exp 0", grant_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    n_tests++; if (dbg_rr_ptr !== '0) begin n_fail++; $display("FAIL rst_rr_ptr: got %0d exp 0", dbg_rr_ptr); end
    n_tests++; if (dbg_beat_cnt !== '0) begin n_fail++; $display("FAIL rst_beat_cnt: got %0d exp 0", dbg_beat_cnt); end
    rif.req_valid = '0;
    rif.req_data  = '0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    vprob = 100; full_mode = 0;
    clear_logs();
    push_beat(0, 32'hA000_0001, 1'b0);
    push_beat(0, 32'hA000_0002, 1'b0);
    push_beat(0, 32'hA000_0003, 1'b1);
    drive();
    drain(50);
    n_tests++; if (first_busy_step != 2) begin n_fail++; $display("FAIL single_busy_cycle: got %0d exp 2", first_busy_step); end
    n_tests++; if (dut_beats != 3) begin n_fail++; $display("FAIL single_beats: got %0d exp 3", dut_beats); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant: got %0d exp 0", grant_id); end
    n_tests++; if (dbg_rr_ptr !== 2'd1) begin n_fail++; $display("FAIL single_rr_ptr: got %0d exp 1", dbg_rr_ptr); end
  endtask

  task automatic test_round_robin();
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    apply_reset();
    vprob = 100; full_mode = 0;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      push_beat(i, $urandom, 1'b1);
      push_beat(i, $urandom, 1'b1);
    end
    drive();
    drain(100);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (dut_grants.size() <= k || dut_grants[k] != exp_order[k]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d exp %0d", k, (dut_grants.size() > k) ? dut_grants[k] : -1, exp_order[k]);
      end
    end
    n_tests++; if (dut_beats != 8) begin n_fail++; $display("FAIL rr_beats: got %0d exp 8", dut_beats); end
    for (int k = 1; k < wr_step.size(); k++) begin
      n_tests++;
      if (wr_step[k] - wr_step[k-1] != 2) begin
        n_fail++; $display("FAIL rr_gap[%0d]: got %0d exp 2", k, wr_step[k] - wr_step[k-1]);
      end
    end
  endtask

  task automatic test_max_burst();
    int runs[$];
    int exp_runs[3];
    int cur;
    exp_runs = '{8, 8, 4};
    apply_reset();
    vprob = 100; full_mode = 0;
    clear_logs();
    for (int b = 0; b < 20; b++) push_beat(2, 32'h2200_0000 + b, (b == 19));
    for (int b = 0; b < 2; b++) begin
      push_beat(0, $urandom, 1'b1);
      push_beat(3, $urandom, 1'b1);
    end
    drive();
    drain(200);
    cur = 0;
    for (int k = 0; k < wr_src.size(); k++) begin
      if (wr_src[k] == 2) cur++;
      else if (cur > 0) begin runs.push_back(cur); cur = 0; end
    end
    if (cur > 0) runs.push_back(cur);
    n_tests++;
    if (runs.size() != 3) begin n_fail++; $display("FAIL maxb_runs: got %0d bursts exp 3", runs.size()); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (runs.size() <= k || runs[k] != exp_runs[k]) begin
        n_fail++; $display("FAIL maxb_len[%0d]: got %0d exp %0d", k, (runs.size() > k) ? runs[k] : -1, exp_runs[k]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int n;
    apply_reset();
    vprob = 100; full_mode = 0;
    clear_logs();
    for (int b = 0; b < 6; b++) push_beat(1, 32'h1100_0000 + b, (b == 5));
    drive();
    n = 0;
    while (dut_beats < 3 && n < 50) begin step(); n++; end
    n_tests++; if (dut_beats != 3) begin n_fail++; $display("FAIL full_pre: got %0d beats exp 3", dut_beats); end
    full_mode = 2;
    drive();
    repeat (5) begin
      step();
      n_tests++;
      if (dbg_beat_cnt !== 4'd3) begin n_fail++; $display("FAIL full_cnt_frozen: got %0d exp 3", dbg_beat_cnt); end
    end
    n_tests++; if (dut_beats != 3) begin n_fail++; $display("FAIL full_no_beat: got %0d beats exp 3", dut_beats); end
    full_mode = 0;
    drive();
    drain(50);
    n_tests++; if (dut_beats != 6) begin n_fail++; $display("FAIL full_total: got %0d beats exp 6", dut_beats); end
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    vprob = 100; full_mode = 0;
    clear_logs();
    push_beat(2, 32'h2BAD_0000, 1'b1);
    drive();
    drain(20);
    clear_logs();
    for (int b = 0; b < 10; b++) push_beat(1, 32'h1B00_0000 + b, (b == 9));
    drive();
    n = 0;
    while (dut_beats < 4 && n < 50) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_en: got %b exp 0", fifo_wr_en); end
    n_tests++; if (rif.req_ready !== '0) begin n_fail++; $display("FAIL mid_rst_ready: got %b exp 0", rif.req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b exp 0", busy); end
    n_tests++; if (grant_id !== '0) begin n_fail++; $display("FAIL mid_rst_grant: got %0d exp 0", grant_id); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_rst_state: got %0d exp 0", dbg_state); end
    n_tests++; if (dbg_rr_ptr !== '0) begin n_fail++; $display("FAIL mid_rst_rr_ptr: got %0d exp 0", dbg_rr_ptr); end
    model_reset();
    clear_logs();
    push_beat(1, 32'h1C00_0000, 1'b0);
    push_beat(1, 32'h1C00_0001, 1'b1);
    push_beat(3, 32'h3C00_0000, 1'b1);
    drive();
    #1 rst_n = 1'b1;
    drain(50);
    n_tests++;
    if (dut_grants.size() == 0 || dut_grants[0] != 1) begin
      n_fail++; $display("FAIL mid_rst_next_grant: got %0d exp 1", (dut_grants.size() > 0) ? dut_grants[0] : -1);
    end
  endtask

  task automatic test_tag();
    logic [OUT_W-1:0] exp_word;
`ifdef ASY_FIFO_ARB_TAG_EN
    exp_word = {2'd3, 32'hDEADBEEF};
`else
    exp_word = 32'hDEADBEEF;
`endif
    apply_reset();
    vprob = 100; full_mode = 0;
    clear_logs();
    push_beat(3, 32'hDEADBEEF, 1'b1);
    drive();
    drain(20);
    n_tests++; if (dut_beats != 1) begin n_fail++; $display("FAIL tag_beats: got %0d exp 1", dut_beats); end
    n_tests++; if (last_wr_data !== exp_word) begin n_fail++; $display("FAIL tag_data: got %h exp %h", last_wr_data, exp_word); end
  endtask

  task automatic test_random();
    int nb;
    for (int r = 0; r < 4; r++) begin
      clear_sources();
      vprob     = $urandom_range(40, 100);
      full_mode = 1;
      fprob     = $urandom_range(0, 40);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) != 0) begin
          nb = $urandom_range(1, 14);
          for (int b = 0; b < nb; b++) push_beat(i, $urandom, (b == nb - 1) || ($urandom_range(9) < 3));
        end
      end
      drive();
      drain(3000);
    end
    full_mode = 0;
  endtask

  initial begin
    vprob = 100; full_mode = 0; fprob = 0;
    clear_logs();
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_fifo_full();
    test_reset_mid();
    test_tag();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
